// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side burst controller for the FIFO block.
// Waits for almost-full, drains the FIFO down to empty in one burst,
// re-registers each word as a stream and checks it against an
// incrementing pattern, keeping a per-burst word count and a saturating
// error count.
//
// Handshake: the FIFO is a "read enable, data next cycle" port. A read is
// issued in any cycle where fifo_rd_en=1 (never while fifo_empty=1); the
// word appears on fifo_dout in the following cycle and is captured at that
// cycle's closing edge. rd_valid is a one-cycle qualifier for rd_data with
// no backpressure: downstream must accept every word it is offered.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic                  fifo_almost_full,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  burst_done,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LAST = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;

    // A read was issued last cycle, so fifo_dout holds a fresh word now.
    logic                  rd_pend_q;
    logic                  rd_pend_d;

    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic                  rd_valid_q;
    logic                  rd_valid_d;
    logic                  burst_done_q;
    logic                  burst_done_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q;
    logic [CNT_WIDTH-1:0]  word_cnt_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q;
    logic [CNT_WIDTH-1:0]  err_cnt_d;
    logic [DATA_WIDTH-1:0] exp_data_q;
    logic [DATA_WIDTH-1:0] exp_data_d;

    logic                  burst_start;
    logic                  word_mismatch;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start on almost-full, end on the first empty cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fifo_almost_full) state_d = READ;
            READ:    if (fifo_empty)       state_d = LAST;
            LAST:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: read enable gated by empty so an empty FIFO is never read.
    always_comb begin
        fifo_rd_en  = (state_q == READ) && !fifo_empty;
        burst_start = (state_q == IDLE) && (state_d == READ);
    end

    // Datapath next values: capture, word count, pattern checker.
    always_comb begin
        rd_pend_d     = fifo_rd_en;
        rd_valid_d    = rd_pend_q;
        rd_data_d     = rd_data_q;
        word_cnt_d    = word_cnt_q;
        err_cnt_d     = err_cnt_q;
        exp_data_d    = exp_data_q;
        word_mismatch = rd_pend_q && (fifo_dout != exp_data_q);
        // burst_done lands in the LAST cycle, alongside the final rd_valid.
        burst_done_d  = (state_q == READ) && (state_d == LAST);

        if (rd_pend_q) begin
            rd_data_d  = fifo_dout;
            word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
            // Resync on the received word so one bad word costs one error.
            exp_data_d = fifo_dout + DATA_WIDTH'(1);
        end

        // No read can be pending in IDLE, so clearing never drops a word.
        if (burst_start) begin
            word_cnt_d = '0;
        end

        if (word_mismatch && (err_cnt_q != {CNT_WIDTH{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q    <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            burst_done_q <= 1'b0;
            word_cnt_q   <= '0;
            err_cnt_q    <= '0;
            exp_data_q   <= '0;
        end else begin
            rd_pend_q    <= rd_pend_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            burst_done_q <= burst_done_d;
            word_cnt_q   <= word_cnt_d;
            err_cnt_q    <= err_cnt_d;
            exp_data_q   <= exp_data_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign burst_done = burst_done_q;
    assign word_cnt   = word_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a behavioural FIFO (queue, data one cycle after
// read enable) feeds directed bursts; each scenario task checks its own
// hand-computed expectations.
module tb_fifo_rd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fifo_empty;
    logic        fifo_almost_full;
    logic [7:0]  fifo_dout;
    logic        fifo_rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        burst_done;
    logic [15:0] word_cnt;
    logic [15:0] err_cnt;

    fifo_rd_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fifo_empty       (fifo_empty),
        .fifo_almost_full (fifo_almost_full),
        .fifo_dout        (fifo_dout),
        .fifo_rd_en       (fifo_rd_en),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .burst_done       (burst_done),
        .word_cnt         (word_cnt),
        .err_cnt          (err_cnt)
    );

    // 50 MHz clock.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    int         tests;
    int         fails;
    logic [7:0] fifo_q[$];
    logic [7:0] got_q[$];
    logic       blip;
    int         n_rd;
    int         n_done;
    int         viol;
    logic [15:0] wc_at_done;
    logic       valid_at_done;

    task automatic set_empty();
        fifo_empty = (fifo_q.size() == 0) || blip;
    endtask

    // One clock: FIFO pops at the edge if read enable was high before it.
    task automatic cycle();
        logic rd;
        rd = fifo_rd_en;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
        set_empty();
        @(negedge clk);
    endtask

    task automatic push_seq(input logic [7:0] start, input int n);
        logic [7:0] v;
        v = start;
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(v);
            v = v + 8'd1;
        end
        set_empty();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        fifo_q.delete();
        fifo_dout = 8'h00;
        blip = 1'b0;
        fifo_almost_full = 1'b0;
        set_empty();
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    // Raise almost_full for one cycle (or hold it), then follow the burst
    // until burst_done, collecting read enables and output words.
    task automatic run_burst(input bit hold_af, input int blip_a, input int blip_b,
                             input int max_cyc);
        bit done_seen;
        done_seen = 1'b0;
        got_q.delete();
        n_rd = 0;
        n_done = 0;
        viol = 0;
        wc_at_done = 16'hDEAD;
        valid_at_done = 1'b0;
        fifo_almost_full = 1'b1;
        cycle();
        if (!hold_af) fifo_almost_full = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            blip = (i == blip_a) || (i == blip_b);
            set_empty();
            #1;
            if (fifo_rd_en) n_rd++;
            if (fifo_rd_en && fifo_empty) viol++;
            if (rd_valid) got_q.push_back(rd_data);
            if (burst_done) begin
                n_done++;
                wc_at_done = word_cnt;
                valid_at_done = rd_valid;
                done_seen = 1'b1;
            end
            if (done_seen) break;
            cycle();
        end
        blip = 1'b0;
        set_empty();
        tests++;
        if (!done_seen) begin
            fails++;
            $display("FAIL burst_timeout: no burst_done within %0d cycles (want burst_done=1)", max_cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fifo_q.delete();
        blip = 1'b0;
        fifo_almost_full = 1'b0;
        fifo_dout = 8'h00;
        set_empty();
        cycle();
        #1;
        tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %0b want 0", fifo_rd_en); end
        tests++; if (rd_data !== 8'h00) begin fails++; $display("FAIL reset_rd_data: got %02h want 00", rd_data); end
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
        tests++; if (burst_done !== 1'b0) begin fails++; $display("FAIL reset_burst_done: got %0b want 0", burst_done); end
        tests++; if (word_cnt !== 16'h0) begin fails++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
        tests++; if (err_cnt !== 16'h0) begin fails++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_basic();
        int bad;
        push_seq(8'h00, 16);
        run_burst(1'b0, -1, -1, 60);
        tests++; if (n_rd != 16) begin fails++; $display("FAIL basic_rd_en_cycles: got %0d want 16", n_rd); end
        tests++; if (got_q.size() != 16) begin fails++; $display("FAIL basic_valid_count: got %0d want 16", got_q.size()); end
        bad = 0;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 8'(i)) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL basic_data: %0d words differ from 00..0F", bad); end
        tests++; if (wc_at_done !== 16'd16) begin fails++; $display("FAIL basic_word_cnt: got %0d want 16", wc_at_done); end
        tests++; if (valid_at_done !== 1'b1) begin fails++; $display("FAIL basic_done_with_valid: got %0b want 1", valid_at_done); end
        tests++; if (err_cnt !== 16'd0) begin fails++; $display("FAIL basic_err_cnt: got %0d want 0", err_cnt); end
        cycle();
        #1;
        tests++; if (burst_done !== 1'b0) begin fails++; $display("FAIL basic_done_single_pulse: got %0b want 0", burst_done); end
    endtask

    task automatic test_wrap();
        // Bring the checker up to 0xFA, then run 250 words across 0xFF->0x00.
        push_seq(8'h10, 234);
        run_burst(1'b0, -1, -1, 300);
        tests++; if (wc_at_done !== 16'd234) begin fails++; $display("FAIL wrap_pre_word_cnt: got %0d want 234", wc_at_done); end
        cycle();
        push_seq(8'hFA, 250);
        run_burst(1'b0, -1, -1, 300);
        tests++; if (wc_at_done !== 16'd250) begin fails++; $display("FAIL wrap_word_cnt: got %0d want 250", wc_at_done); end
        tests++; if (err_cnt !== 16'd0) begin fails++; $display("FAIL wrap_err_cnt: got %0d want 0", err_cnt); end
        tests++; if (got_q.size() != 250 || got_q[5] !== 8'hFF || got_q[6] !== 8'h00 || got_q[249] !== 8'hF3) begin
            fails++; $display("FAIL wrap_data: size %0d want 250, words 5/6/249 must be FF/00/F3", got_q.size());
        end
        cycle();
    endtask

    task automatic test_reset_mid_burst();
        int nv;
        push_seq(8'h00, 16);
        fifo_almost_full = 1'b1;
        cycle();
        fifo_almost_full = 1'b0;
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (rd_valid) nv++;
            if (nv == 7) break;
            cycle();
        end
        tests++; if (nv != 7) begin fails++; $display("FAIL midrst_reach_word7: got %0d words want 7", nv); end
        rst_n = 1'b0;
        #1;
        tests++; if ({fifo_rd_en, rd_valid, burst_done, rd_data, word_cnt, err_cnt} !== '0) begin
            fails++; $display("FAIL midrst_outputs: rd_en %0b valid %0b done %0b data %02h wc %0d err %0d want all 0",
                              fifo_rd_en, rd_valid, burst_done, rd_data, word_cnt, err_cnt);
        end
        fifo_q.delete();
        set_empty();
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        push_seq(8'h00, 8);
        #1;
        tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL midrst_idle_after_release: rd_en got %0b want 0", fifo_rd_en); end
        run_burst(1'b0, -1, -1, 40);
        tests++; if (wc_at_done !== 16'd8 || err_cnt !== 16'd0) begin
            fails++; $display("FAIL midrst_exp_restart: wc %0d err %0d want 8 and 0", wc_at_done, err_cnt);
        end
        cycle();
    endtask

    task automatic test_corrupt();
        apply_reset();
        push_seq(8'h00, 16);
        fifo_q[5] = 8'hAA;
        run_burst(1'b0, -1, -1, 60);
        tests++; if (err_cnt !== 16'd2) begin fails++; $display("FAIL corrupt_err_cnt: got %0d want 2", err_cnt); end
        tests++; if (got_q.size() != 16 || got_q[5] !== 8'hAA || got_q[6] !== 8'h06) begin
            fails++; $display("FAIL corrupt_data: size %0d want 16, words 5/6 must be AA/06", got_q.size());
        end
        tests++; if (wc_at_done !== 16'd16) begin fails++; $display("FAIL corrupt_word_cnt: got %0d want 16", wc_at_done); end
        cycle();
    endtask

    task automatic test_empty_blip();
        push_seq(8'h10, 16);
        run_burst(1'b0, 4, 9, 60);
        tests++; if (viol != 0) begin fails++; $display("FAIL blip_read_while_empty: got %0d reads want 0", viol); end
        tests++; if (n_rd != 4 || wc_at_done !== 16'd4) begin
            fails++; $display("FAIL blip_first_burst: rd_en %0d wc %0d want 4 and 4", n_rd, wc_at_done);
        end
        cycle();
        run_burst(1'b0, -1, -1, 60);
        tests++; if (wc_at_done !== 16'd12 || got_q.size() != 12 || got_q[0] !== 8'h14) begin
            fails++; $display("FAIL blip_second_burst: wc %0d words %0d want 12 and 12 starting 14", wc_at_done, got_q.size());
        end
        tests++; if (err_cnt !== 16'd2) begin fails++; $display("FAIL blip_err_cnt: got %0d want 2", err_cnt); end
        cycle();
    endtask

    task automatic test_flags_inconsistent();
        run_burst(1'b0, -1, -1, 10);
        tests++; if (n_rd != 0 || wc_at_done !== 16'd0 || n_done != 1) begin
            fails++; $display("FAIL af_with_empty: rd_en %0d wc %0d done %0d want 0 0 1", n_rd, wc_at_done, n_done);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        logic [2:0] done_seq;
        push_seq(8'h20, 4);
        run_burst(1'b1, -1, -1, 20);
        tests++; if (wc_at_done !== 16'd4) begin fails++; $display("FAIL b2b_word_cnt: got %0d want 4", wc_at_done); end
        // LAST -> IDLE -> READ (empty) -> LAST: next pulse three cycles on.
        for (int i = 0; i < 3; i++) begin
            if (i == 2) fifo_almost_full = 1'b0;
            cycle();
            #1;
            done_seq[i] = burst_done;
        end
        tests++; if (done_seq !== 3'b100) begin fails++; $display("FAIL b2b_restart: done over 3 cycles got %03b want 100", done_seq); end
        cycle();
    endtask

    task automatic test_saturate();
        force dut.err_cnt_q = 16'hFFFE;
        cycle();
        release dut.err_cnt_q;
        cycle();
        // Checker expects 0x24; three 0x00 words all mismatch.
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'h00);
        set_empty();
        run_burst(1'b0, -1, -1, 20);
        tests++; if (err_cnt !== 16'hFFFF) begin fails++; $display("FAIL saturate_err_cnt: got %04h want FFFF", err_cnt); end
        tests++; if (wc_at_done !== 16'd3) begin fails++; $display("FAIL saturate_word_cnt: got %0d want 3", wc_at_done); end
        cycle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        blip = 1'b0;
        fifo_almost_full = 1'b0;
        fifo_dout = 8'h00;
        fifo_empty = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_reset_mid_burst();
        test_corrupt();
        test_empty_blip();
        test_flags_inconsistent();
        test_back_to_back();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the FIFO block: waits for the FIFO to report almost-full, then drains it in one burst down to empty. Each word is re-registered as an output stream and checked against the incrementing pattern the write side produces. It sits between the FIFO read port and downstream logic or a bench monitor, and provides error and word counts for pass/fail checking.

## Interface
- DATA_WIDTH, 8, FIFO data width.
- CNT_WIDTH, 16, width of the word counter and the error counter.
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1  FIFO empty flag, read-clock domain.
- fifo_almost_full  input  1  FIFO almost-full flag, starts a burst.
- fifo_dout  input  DATA_WIDTH  FIFO read data; valid 1 cycle after fifo_rd_en.
- fifo_rd_en  output  1  FIFO read enable.
- rd_data  output  DATA_WIDTH  registered copy of the read word.
- rd_valid  output  1  rd_data qualifier, 1-cycle pulse per word.
- burst_done  output  1  1-cycle pulse at the end of each burst.
- word_cnt  output  CNT_WIDTH  words read in the current or last burst.
- err_cnt  output  CNT_WIDTH  total pattern mismatches since reset; saturating.

## Operation
- FSM states are IDLE, READ and LAST.
- IDLE → READ when fifo_almost_full=1. Entering READ clears word_cnt to 0.
- READ:
  - fifo_rd_en = (state==READ) && !fifo_empty, combinational, so the FIFO is never read while empty.
  - READ → LAST on the first cycle with fifo_empty=1.
- LAST:
  - Lasts one cycle and captures the data from the final read.
  - Pulses burst_done.
  - LAST → IDLE unconditionally.
- A read is issued when fifo_rd_en=1. In the cycle after an issued read, fifo_dout is sampled:
  - rd_data <= fifo_dout and rd_valid <= 1.
  - word_cnt increments, wrapping modulo 2^CNT_WIDTH.
- Checker:
  - exp_data resets to 0.
  - On each sampled word, if fifo_dout != exp_data, err_cnt increments, holding at 2^CNT_WIDTH-1.
  - exp_data <= fifo_dout + 1 on every sampled word, match or not. This resyncs the checker after an error.
  - exp_data wraps modulo 2^DATA_WIDTH (0xFF → 0x00 at width 8).
- If fifo_empty deasserts again while in LAST or IDLE, it is ignored. A new burst needs fifo_almost_full.
- If fifo_almost_full stays high in IDLE after LAST, a new burst starts on the next cycle.

## Timing
- Reset values (asynchronous, rst_n=0):
  - state=IDLE.
  - fifo_rd_en=0, since state forces it.
  - rd_data=0, rd_valid=0, burst_done=0.
  - word_cnt=0, err_cnt=0, exp_data=0.
- Latency:
  - fifo_rd_en high at edge N gives rd_valid/rd_data at edge N+1, checked against exp_data at N+1.
  - err_cnt shows the update after edge N+1.
- In steady state, a burst of K words gives fifo_rd_en high for K consecutive cycles if empty never blips. rd_valid is high for K cycles, delayed by 1.
- burst_done asserts in the same cycle as the last rd_valid of the burst, at the exit from LAST. word_cnt equals K when burst_done is high.
- If empty toggles mid-burst, the first empty cycle ends the burst. Any remaining words are read in the next burst.
- Reset mid-burst: every output returns to its reset value immediately. fifo_rd_en drops combinationally with the state. No partial burst_done is produced.
- Simultaneous fifo_almost_full=1 and fifo_empty=1 are treated as inconsistent FIFO flags. In IDLE the FSM still enters READ, then goes to LAST on the next cycle with zero reads: word_cnt=0, and burst_done still pulses.

## Test plan
- Write 0x00..0x0F, raise almost_full, then drain:
  - fifo_rd_en high for 16 cycles.
  - rd_data 0x00..0x0F on consecutive rd_valid.
  - word_cnt=16, err_cnt=0, burst_done one pulse.
- Write 250 words starting at 0xFA so the pattern wraps past 0xFF: no errors across the 0xFF→0x00 wrap, word_cnt=250.
- Corrupt word 5 (0x05 → 0xAA), then continue with 0x06:
  - err_cnt=2: 0xAA≠0x05, and 0x06≠0xAB after the resync.
  - The following words give no further errors.
- Hold fifo_empty=1 on cycles 4 and 9 of a burst:
  - fifo_rd_en is never high while empty.
  - The burst ends at cycle 4, word_cnt=4.
  - The next almost_full burst reads the rest.
- Pull rst_n low at word 7 of a 16-word burst:
  - All outputs are 0 immediately.
  - After release the FSM is in IDLE.
  - The next burst starts with exp_data=0.
- Force err_cnt to 0xFFFE, then inject 3 mismatches: err_cnt holds at 0xFFFF.
